// File: rtl/boot_loader.sv
// Boot loader: consumes a header + program/data word stream, fills the core's memories,
// then releases the core from reset. All outputs are registered.
module boot_loader #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned PM_DEPTH = 256,
    parameter int unsigned DM_DEPTH = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic                          in_valid,
    input  logic [BITS-1:0]               in_data,
    output logic                          in_ready,
    output logic                          pm_write_en,
    output logic [$clog2(PM_DEPTH)+1:0]   pm_write_address,
    output logic [BITS-1:0]               pm_data_in,
    output logic                          dm_write_en,
    output logic [$clog2(DM_DEPTH)-1:0]   dm_write_address_load,
    output logic [BITS-1:0]               dm_data_in_load,
    output logic                          cpu_rstn,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);
    localparam int unsigned PM_AW = $clog2(PM_DEPTH);
    localparam int unsigned DM_AW = $clog2(DM_DEPTH);
    // Counters one bit wider than the address so a full-depth count fits.
    localparam int unsigned PM_CW = $clog2(PM_DEPTH + 1);
    localparam int unsigned DM_CW = $clog2(DM_DEPTH + 1);

    typedef enum logic [2:0] {
        StIdle, StHeader, StLoadPm, StLoadDm, StDrain, StRun, StError
    } state_t;

    state_t             r_state;
    state_t             w_state_d;
    logic [PM_CW-1:0]   r_pm_n, r_pm_cnt;
    logic [DM_CW-1:0]   r_dm_m, r_dm_cnt;
    logic               r_in_ready, r_pm_we, r_dm_we, r_cpu_rstn, r_busy, r_done, r_error;
    logic [PM_AW+1:0]   r_pm_addr;
    logic [DM_AW-1:0]   r_dm_addr;
    logic [BITS-1:0]    r_pm_data, r_dm_data;
    logic               w_xfer, w_hdr_bad, w_pm_last, w_dm_last;
    logic [15:0]        w_hdr_n, w_hdr_m;

    always_comb begin
        w_xfer    = in_valid && r_in_ready;
        w_hdr_n   = in_data[15:0];
        w_hdr_m   = in_data[31:16];
        w_hdr_bad = (32'(w_hdr_n) > PM_DEPTH) || (32'(w_hdr_m) > DM_DEPTH);
        w_pm_last = (r_pm_cnt == r_pm_n - PM_CW'(1));
        w_dm_last = (r_dm_cnt == r_dm_m - DM_CW'(1));
        w_state_d = r_state;
        case (r_state)
            StIdle, StRun, StError: if (start) w_state_d = StHeader;
            StHeader: begin
                if (w_xfer) begin
                    if (w_hdr_bad)           w_state_d = StError;
                    else if (w_hdr_n != '0)  w_state_d = StLoadPm;
                    else if (w_hdr_m != '0)  w_state_d = StLoadDm;
                    else                     w_state_d = StDrain;
                end
            end
            StLoadPm: if (w_xfer && w_pm_last) w_state_d = (r_dm_m != '0) ? StLoadDm : StDrain;
            StLoadDm: if (w_xfer && w_dm_last) w_state_d = StDrain;
            StDrain:  w_state_d = StRun;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_pm_n     <= '0;
            r_pm_cnt   <= '0;
            r_dm_m     <= '0;
            r_dm_cnt   <= '0;
            r_in_ready <= 1'b0;
            r_pm_we    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_pm_addr  <= '0;
            r_dm_addr  <= '0;
            r_pm_data  <= '0;
            r_dm_data  <= '0;
            r_cpu_rstn <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            // Status outputs are decoded from the next state so they line up with it.
            r_in_ready <= (w_state_d == StHeader) || (w_state_d == StLoadPm) ||
                          (w_state_d == StLoadDm);
            r_busy     <= (w_state_d == StHeader) || (w_state_d == StLoadPm) ||
                          (w_state_d == StLoadDm) || (w_state_d == StDrain);
            r_cpu_rstn <= (w_state_d == StRun);
            r_done     <= (w_state_d == StRun);
            r_error    <= (w_state_d == StError);
            r_pm_we    <= 1'b0;
            r_dm_we    <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    StHeader: begin
                        r_pm_n   <= PM_CW'(w_hdr_n);
                        r_dm_m   <= DM_CW'(w_hdr_m);
                        r_pm_cnt <= '0;
                        r_dm_cnt <= '0;
                    end
                    StLoadPm: begin
                        r_pm_we   <= 1'b1;
                        r_pm_addr <= {r_pm_cnt[PM_AW-1:0], 2'b00};
                        r_pm_data <= in_data;
                        r_pm_cnt  <= r_pm_cnt + PM_CW'(1);
                    end
                    StLoadDm: begin
                        r_dm_we   <= 1'b1;
                        r_dm_addr <= r_dm_cnt[DM_AW-1:0];
                        r_dm_data <= in_data;
                        r_dm_cnt  <= r_dm_cnt + DM_CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready              = r_in_ready;
    assign pm_write_en           = r_pm_we;
    assign pm_write_address      = r_pm_addr;
    assign pm_data_in            = r_pm_data;
    assign dm_write_en           = r_dm_we;
    assign dm_write_address_load = r_dm_addr;
    assign dm_data_in_load       = r_dm_data;
    assign cpu_rstn              = r_cpu_rstn;
    assign busy                  = r_busy;
    assign done                  = r_done;
    assign error                 = r_error;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: memory writes are logged by a monitor and compared
// against hand-computed addresses, data and cycle timing.
module tb_boot_loader;
    logic        clk, rstn, start, in_valid;
    logic [31:0] in_data;
    logic        in_ready, pm_write_en, dm_write_en, cpu_rstn, busy, done, error;
    logic [9:0]  pm_write_address;
    logic [7:0]  dm_write_address_load;
    logic [31:0] pm_data_in, dm_data_in_load;

    int checks = 0;
    int errors = 0;

    logic [9:0]  pm_addr_q[$];
    logic [31:0] pm_data_q[$];
    logic [7:0]  dm_addr_q[$];
    logic [31:0] dm_data_q[$];
    int          spurious  = 0;
    int          both_high = 0;
    logic        last_acc  = 1'b0;

    boot_loader #(.BITS(32), .PM_DEPTH(256), .DM_DEPTH(256)) dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pm_write_en(pm_write_en), .pm_write_address(pm_write_address),
        .pm_data_in(pm_data_in), .dm_write_en(dm_write_en),
        .dm_write_address_load(dm_write_address_load), .dm_data_in_load(dm_data_in_load),
        .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-side view: a write lands at the edge where its strobe is high.
    always @(posedge clk) begin
        if (pm_write_en) begin
            pm_addr_q.push_back(pm_write_address);
            pm_data_q.push_back(pm_data_in);
            if (!last_acc) spurious++;
        end
        if (dm_write_en) begin
            dm_addr_q.push_back(dm_write_address_load);
            dm_data_q.push_back(dm_data_in_load);
            if (!last_acc) spurious++;
        end
        if (pm_write_en && dm_write_en) both_high++;
        last_acc = in_valid && in_ready;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        pm_addr_q.delete(); pm_data_q.delete(); dm_addr_q.delete(); dm_data_q.delete();
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        tick(); tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("FAIL reset_cpu_rstn: got %b want 0", cpu_rstn); end
        checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {busy, done, error}); end
        checks++; if ({pm_write_en, dm_write_en} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b want 00", {pm_write_en, dm_write_en}); end
        checks++; if ({pm_write_address, pm_data_in, dm_write_address_load, dm_data_in_load} !== 82'd0) begin
            errors++; $display("FAIL reset_addr_data: got %h want 0", {pm_write_address, pm_data_in, dm_write_address_load, dm_data_in_load}); end
        rstn = 1'b1;
        tick(); tick();
        checks++; if ({in_ready, busy, cpu_rstn} !== 3'b000) begin errors++; $display("FAIL idle_hold: got %b want 000", {in_ready, busy, cpu_rstn}); end
    endtask

    task automatic test_basic_load;
        logic [31:0] words [5];
        words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, 32'hEEEE_0005};
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if ({in_ready, busy} !== 2'b11) begin errors++; $display("FAIL basic_header_ready: got %b want 11", {in_ready, busy}); end
        in_valid = 1'b1; in_data = 32'h0002_0003; tick();
        checks++; if (pm_write_en !== 1'b0) begin errors++; $display("FAIL basic_no_hdr_write: got %b want 0", pm_write_en); end
        for (int k = 0; k < 3; k++) begin
            in_data = words[k]; tick();
            checks++; if ({pm_write_en, dm_write_en, pm_write_address, pm_data_in} !== {2'b10, 10'(4 * k), words[k]}) begin
                errors++; $display("FAIL basic_pm_%0d: got we=%b%b a=%0d d=%h want we=10 a=%0d d=%h", k,
                    pm_write_en, dm_write_en, pm_write_address, pm_data_in, 4 * k, words[k]); end
        end
        for (int k = 0; k < 2; k++) begin
            in_data = words[3 + k]; tick();
            checks++; if ({pm_write_en, dm_write_en, dm_write_address_load, dm_data_in_load} !== {2'b01, 8'(k), words[3 + k]}) begin
                errors++; $display("FAIL basic_dm_%0d: got we=%b%b a=%0d d=%h want we=01 a=%0d d=%h", k,
                    pm_write_en, dm_write_en, dm_write_address_load, dm_data_in_load, k, words[3 + k]); end
        end
        // Drain cycle: final strobe visible, core still held.
        checks++; if ({in_ready, busy, cpu_rstn, done} !== 4'b0100) begin errors++; $display("FAIL basic_drain: got %b want 0100", {in_ready, busy, cpu_rstn, done}); end
        in_valid = 1'b0; tick();
        checks++; if ({cpu_rstn, done, busy, dm_write_en} !== 4'b1100) begin errors++; $display("FAIL basic_run: got %b want 1100", {cpu_rstn, done, busy, dm_write_en}); end
        checks++; if (pm_addr_q.size() != 3 || dm_addr_q.size() != 2) begin
            errors++; $display("FAIL basic_counts: got pm=%0d dm=%0d want pm=3 dm=2", pm_addr_q.size(), dm_addr_q.size()); end
    endtask

    task automatic test_empty_header;
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if ({cpu_rstn, done, in_ready} !== 3'b001) begin errors++; $display("FAIL empty_restart: got %b want 001", {cpu_rstn, done, in_ready}); end
        in_valid = 1'b1; in_data = 32'h0000_0000; tick();
        checks++; if ({in_ready, busy, done} !== 3'b010) begin errors++; $display("FAIL empty_drain: got %b want 010", {in_ready, busy, done}); end
        in_valid = 1'b0; tick();
        checks++; if ({done, cpu_rstn, busy} !== 3'b110) begin errors++; $display("FAIL empty_run: got %b want 110", {done, cpu_rstn, busy}); end
        checks++; if (pm_addr_q.size() + dm_addr_q.size() != 0) begin
            errors++; $display("FAIL empty_no_writes: got %0d want 0", pm_addr_q.size() + dm_addr_q.size()); end
    endtask

    task automatic test_error;
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0101; tick();
        checks++; if ({error, cpu_rstn, busy, in_ready} !== 4'b1000) begin errors++; $display("FAIL err_pm_257: got %b want 1000", {error, cpu_rstn, busy, in_ready}); end
        for (int k = 0; k < 3; k++) begin in_data = 32'h1234_0000 + k; tick(); end
        in_valid = 1'b0;
        checks++; if ({error, pm_addr_q.size() == 0, dm_addr_q.size() == 0} !== 3'b111) begin
            errors++; $display("FAIL err_hold_no_writes: got err=%b pm=%0d dm=%0d want 1 0 0", error, pm_addr_q.size(), dm_addr_q.size()); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if ({error, in_ready} !== 2'b01) begin errors++; $display("FAIL err_clear: got %b want 01", {error, in_ready}); end
        in_valid = 1'b1; in_data = 32'h0101_0000; tick(); in_valid = 1'b0;
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_dm_257: got %b want 1", error); end
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0001_0000; tick();
        in_data = 32'h5A5A_A5A5; tick(); in_valid = 1'b0;
        checks++; if ({dm_write_en, pm_write_en, dm_write_address_load, dm_data_in_load, error} !== {2'b10, 8'd0, 32'h5A5A_A5A5, 1'b0}) begin
            errors++; $display("FAIL err_recover_dm: got we=%b%b a=%0d d=%h err=%b want 10 0 5a5aa5a5 0",
                dm_write_en, pm_write_en, dm_write_address_load, dm_data_in_load, error); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL err_recover_done: got %b want 1", done); end
    endtask

    task automatic test_random_valid;
        logic [15:0] pat;
        int          acc;
        logic        rdy;
        pat = 16'b0110_1001_1101_0100;
        acc = 0;
        clear_logs();
        spurious = 0;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0004; tick();
        for (int c = 0; c < 40 && acc < 4; c++) begin
            in_valid = pat[c % 16];
            in_data  = 32'hC0DE_0000 + 32'(acc);
            rdy = in_ready;
            tick();
            if (in_valid && rdy) acc++;
        end
        in_valid = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL rv_accepted: got %0d want 4", acc); end
        tick();
        checks++; if (pm_addr_q.size() != 4) begin errors++; $display("FAIL rv_count: got %0d want 4", pm_addr_q.size()); end
        for (int k = 0; k < 4 && k < pm_addr_q.size(); k++) begin
            checks++; if ({pm_addr_q[k], pm_data_q[k]} !== {10'(4 * k), 32'hC0DE_0000 + 32'(k)}) begin
                errors++; $display("FAIL rv_entry_%0d: got a=%0d d=%h want a=%0d d=%h", k, pm_addr_q[k], pm_data_q[k],
                    4 * k, 32'hC0DE_0000 + 32'(k)); end
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL rv_spurious: got %0d want 0", spurious); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rv_done: got %b want 1", done); end
    endtask

    task automatic test_full_depth;
        int bad;
        bad = 0;
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0100; tick();
        for (int k = 0; k < 256; k++) begin in_data = 32'h1000_0000 + 32'(k); tick(); end
        in_valid = 1'b0;
        checks++; if ({pm_write_address, busy} !== {10'd1020, 1'b1}) begin
            errors++; $display("FAIL full_last_addr: got a=%0d busy=%b want 1020 1", pm_write_address, busy); end
        tick();
        checks++; if (pm_addr_q.size() != 256) begin errors++; $display("FAIL full_count: got %0d want 256", pm_addr_q.size()); end
        for (int k = 0; k < pm_addr_q.size(); k++)
            if ({pm_addr_q[k], pm_data_q[k]} !== {10'(4 * k), 32'h1000_0000 + 32'(k)}) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL full_entries: got %0d bad entries want 0", bad); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", done); end
    endtask

    task automatic test_reset_mid_load;
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0004; tick();
        in_data = 32'h7777_0000; tick();
        in_data = 32'h7777_0001; tick();
        rstn = 1'b0; in_data = 32'h7777_0002; tick();
        checks++; if ({pm_write_en, in_ready, cpu_rstn, busy, done, error} !== 6'b000000) begin
            errors++; $display("FAIL rst_mid_status: got %b want 000000", {pm_write_en, in_ready, cpu_rstn, busy, done, error}); end
        checks++; if ({pm_write_address, pm_data_in} !== 42'd0) begin
            errors++; $display("FAIL rst_mid_addr: got a=%0d d=%h want 0 0", pm_write_address, pm_data_in); end
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        in_valid = 1'b0;
        checks++; if (pm_addr_q.size() != 2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_more: got writes=%0d rdy=%b want 2 0", pm_addr_q.size(), in_ready); end
    endtask

    task automatic test_restart_in_run;
        start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0002; tick();
        in_data = 32'h0BAD_0000; tick();
        in_data = 32'h0BAD_0001; tick();
        in_valid = 1'b0; tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rr_first_done: got %b want 1", done); end
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if ({cpu_rstn, done, in_ready} !== 3'b001) begin errors++; $display("FAIL rr_release_drop: got %b want 001", {cpu_rstn, done, in_ready}); end
        in_valid = 1'b1; in_data = 32'h0000_0001; tick();
        in_data = 32'h600D_0000; tick(); in_valid = 1'b0;
        checks++; if ({pm_write_en, pm_write_address, pm_data_in} !== {1'b1, 10'd0, 32'h600D_0000}) begin
            errors++; $display("FAIL rr_overwrite: got we=%b a=%0d d=%h want 1 0 600d0000", pm_write_en, pm_write_address, pm_data_in); end
        tick();
        checks++; if ({done, pm_addr_q.size() == 1} !== 2'b11) begin
            errors++; $display("FAIL rr_done: got done=%b writes=%0d want 1 1", done, pm_addr_q.size()); end
    endtask

    task automatic test_exclusive_strobes;
        checks++; if (both_high != 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps want 0", both_high); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_empty_header();
        test_error();
        test_random_valid();
        test_full_depth();
        test_reset_mid_load();
        test_restart_in_run();
        test_exclusive_strobes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
